// File: rtl/pulse_peak_analyzer.sv
// Pulse peak analyzer: finds threshold crossings and measures peak, peak time, width and pile-up of each pulse.
// Latency: a record appears in the output register one cycle after the sample that ends the pulse.
// Backpressure: one-deep output register; a record that arrives while a record is still held is dropped and counted in lost_count.
module pulse_peak_analyzer #(
    parameter int DATA_WIDTH  = 16,
    parameter int TIME_WIDTH  = 16,
    parameter int WIDTH_BITS  = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int DEAD_TIME   = 4,
    parameter int PILEUP_HYST = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] threshold,
    input  logic signed [DATA_WIDTH-1:0] input_data,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic signed [DATA_WIDTH-1:0] result_peak,
    output logic [TIME_WIDTH-1:0]        result_time,
    output logic [WIDTH_BITS-1:0]        result_width,
    output logic                         result_pileup,
    output logic [CNT_WIDTH-1:0]         pulse_count,
    output logic [CNT_WIDTH-1:0]         lost_count,
    output logic                         busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_DEAD  = 2'd2;

    // Dead-time counter is sized so DEAD_TIME=0 still yields a legal width.
    localparam int DCW = $clog2(DEAD_TIME + 2);
    localparam logic [DCW-1:0] DEAD_LOAD = DCW'((DEAD_TIME > 0) ? DEAD_TIME - 1 : 0);
    localparam logic signed [DATA_WIDTH:0] HYST = $signed((DATA_WIDTH+1)'(PILEUP_HYST));

    logic [1:0]                   state;
    logic [TIME_WIDTH-1:0]        ts;
    logic signed [DATA_WIDTH-1:0] peak;
    logic signed [DATA_WIDTH-1:0] valley;
    logic [TIME_WIDTH-1:0]        peak_time;
    logic [WIDTH_BITS-1:0]        width;
    logic                         pileup;
    logic [DCW-1:0]               dead_cnt;

    logic                         above;
    logic                         new_peak;
    logic signed [DATA_WIDTH-1:0] valley_nx;
    logic signed [DATA_WIDTH:0]   data_ext;
    logic signed [DATA_WIDTH:0]   valley_lim;
    logic                         pile_hit;
    logic [WIDTH_BITS-1:0]        width_nx;
    logic                         commit;
    logic                         accept;

    // Per-sample tracking decisions; pile-up is judged against the valley after this sample's update,
    // so a new peak or a new minimum can never flag pile-up by itself.
    always_comb begin
        above      = input_data > threshold;
        new_peak   = input_data > peak;
        valley_nx  = valley;
        if (new_peak || (input_data < valley)) begin
            valley_nx = input_data;
        end
        data_ext   = {input_data[DATA_WIDTH-1], input_data};
        valley_lim = {valley_nx[DATA_WIDTH-1], valley_nx} + HYST;
        pile_hit   = data_ext > valley_lim;
        width_nx   = (width == {WIDTH_BITS{1'b1}}) ? width : width + WIDTH_BITS'(1);
        commit     = enable && (state == ST_TRACK) && !above;
        accept     = result_valid && result_ready;
    end

    assign busy = (state != ST_IDLE);

    // Timestamp counter and the pulse-tracking state machine.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ts        <= '0;
            peak      <= '0;
            valley    <= '0;
            peak_time <= '0;
            width     <= '0;
            pileup    <= 1'b0;
            dead_cnt  <= '0;
        end else begin
            ts <= ts + TIME_WIDTH'(1);
            if (!enable) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (above) begin
                            state     <= ST_TRACK;
                            peak      <= input_data;
                            peak_time <= ts;
                            width     <= WIDTH_BITS'(1);
                            valley    <= input_data;
                            pileup    <= 1'b0;
                        end
                    end
                    ST_TRACK: begin
                        if (above) begin
                            width  <= width_nx;
                            valley <= valley_nx;
                            if (new_peak) begin
                                peak      <= input_data;
                                peak_time <= ts;
                            end
                            if (pile_hit) begin
                                pileup <= 1'b1;
                            end
                        end else if (DEAD_TIME == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_DEAD;
                            dead_cnt <= DEAD_LOAD;
                        end
                    end
                    ST_DEAD: begin
                        if (dead_cnt == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            dead_cnt <= dead_cnt - DCW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Output record register with drop-on-full policy and saturating statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_valid  <= 1'b0;
            result_peak   <= '0;
            result_time   <= '0;
            result_width  <= '0;
            result_pileup <= 1'b0;
            pulse_count   <= '0;
            lost_count    <= '0;
        end else if (commit) begin
            if (pulse_count != {CNT_WIDTH{1'b1}}) begin
                pulse_count <= pulse_count + CNT_WIDTH'(1);
            end
            if (!result_valid || result_ready) begin
                result_valid  <= 1'b1;
                result_peak   <= peak;
                result_time   <= peak_time;
                result_width  <= width;
                result_pileup <= pileup;
            end else if (lost_count != {CNT_WIDTH{1'b1}}) begin
                lost_count <= lost_count + CNT_WIDTH'(1);
            end
        end else if (accept) begin
            result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_peak_analyzer.sv
// Testbench for pulse_peak_analyzer: table of single-pulse vectors plus hand sequences
// for backpressure, dead time, enable abort, width saturation, timestamp wrap and async reset.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
module tb_pulse_peak_analyzer;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               enable = 1'b0;
    logic signed [15:0] threshold;
    logic signed [15:0] input_data;
    logic               result_valid;
    logic               result_ready = 1'b1;
    logic signed [15:0] result_peak;
    logic [15:0]        result_time;
    logic [7:0]         result_width;
    logic               result_pileup;
    logic [15:0]        pulse_count;
    logic [15:0]        lost_count;
    logic               busy;

    pulse_peak_analyzer #(
        .DATA_WIDTH(16), .TIME_WIDTH(16), .WIDTH_BITS(8), .CNT_WIDTH(16),
        .DEAD_TIME(4), .PILEUP_HYST(32)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .threshold(threshold),
        .input_data(input_data), .result_valid(result_valid), .result_ready(result_ready),
        .result_peak(result_peak), .result_time(result_time), .result_width(result_width),
        .result_pileup(result_pileup), .pulse_count(pulse_count), .lost_count(lost_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic signed [15:0] IDLE_V = -16'sd1000;

    typedef struct {
        logic signed [15:0]      thr;
        int                      n;
        logic [7:0][15:0]        s;
        logic signed [15:0]      exp_peak;
        int                      exp_idx;
        int                      exp_width;
        logic                    exp_pile;
    } vec_t;

    vec_t        vecs[6];
    int          total = 0;
    int          bad = 0;
    logic [15:0] tb_ts;
    int          exp_pc = 0;
    int          exp_lost = 0;
    logic [15:0] start_ts;
    logic [15:0] exp_time;

    task automatic chk(input string nm, input int act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Present one sample, let the edge sample it, and land 1 unit after the edge.
    task automatic step(input logic signed [15:0] v);
        input_data = v;
        @(posedge clk);
        #1;
        tb_ts = tb_ts + 16'd1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(IDLE_V);
    endtask

    initial begin
        vecs[0] = '{thr: 16'sd100, n: 5, s: {16'd0, 16'd0, 16'd0, 16'd90, 16'd200, 16'd300, 16'd150, 16'd50},
                    exp_peak: 16'sd300, exp_idx: 2, exp_width: 3, exp_pile: 1'b0};
        vecs[1] = '{thr: 16'sd100, n: 6, s: {16'd0, 16'd0, 16'd80, 16'd300, 16'd260, 16'd200, 16'd300, 16'd150},
                    exp_peak: 16'sd300, exp_idx: 1, exp_width: 5, exp_pile: 1'b1};
        vecs[2] = '{thr: -16'sd50, n: 3, s: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, -16'sd60, -16'sd10, -16'sd40},
                    exp_peak: -16'sd10, exp_idx: 1, exp_width: 2, exp_pile: 1'b0};
        vecs[3] = '{thr: 16'sd100, n: 6, s: {16'd0, 16'd0, 16'd50, 16'd333, 16'd332, 16'd300, 16'd400, 16'd200},
                    exp_peak: 16'sd400, exp_idx: 1, exp_width: 5, exp_pile: 1'b1};
        vecs[4] = '{thr: 16'sd100, n: 3, s: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd100, 16'd101, 16'd100},
                    exp_peak: 16'sd101, exp_idx: 1, exp_width: 1, exp_pile: 1'b0};
        vecs[5] = '{thr: 16'sd50, n: 4, s: {16'd0, 16'd0, 16'd0, 16'd0, 16'd20, 16'd140, 16'd100, 16'd500},
                    exp_peak: 16'sd500, exp_idx: 0, exp_width: 3, exp_pile: 1'b1};

        threshold  = 16'sd100;
        input_data = IDLE_V;
        tb_ts      = 16'd0;

        // Reset state.
        @(posedge clk);
        #1;
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_peak", int'(result_peak), 0);
        chk("rst_pcount", int'(pulse_count), 0);
        chk("rst_lost", int'(lost_count), 0);
        chk("rst_busy", int'(busy), 0);
        reset  = 1'b1;
        enable = 1'b1;
        idle(10);

        // Table-driven single pulses.
        for (int i = 0; i < 6; i++) begin
            threshold = vecs[i].thr;
            start_ts  = tb_ts;
            for (int j = 0; j < vecs[i].n; j++) step($signed(vecs[i].s[j]));
            exp_pc   = exp_pc + 1;
            exp_time = start_ts + 16'(vecs[i].exp_idx);
            chk($sformatf("v%0d_valid", i), int'(result_valid), 1);
            chk($sformatf("v%0d_peak", i), int'(result_peak), int'(vecs[i].exp_peak));
            chk($sformatf("v%0d_time", i), int'(result_time), int'(exp_time));
            chk($sformatf("v%0d_width", i), int'(result_width), vecs[i].exp_width);
            chk($sformatf("v%0d_pile", i), int'(result_pileup), int'(vecs[i].exp_pile));
            chk($sformatf("v%0d_pcount", i), int'(pulse_count), exp_pc);
            idle(6);
            chk($sformatf("v%0d_drained", i), int'(result_valid), 0);
        end

        // Backpressure: held record, drop, then simultaneous accept and commit.
        threshold    = 16'sd100;
        result_ready = 1'b0;
        step(16'sd200); step(16'sd300); step(16'sd0);
        exp_pc = exp_pc + 1;
        chk("bp_first_peak", int'(result_peak), 300);
        idle(6);
        step(16'sd400); step(16'sd0);
        exp_pc   = exp_pc + 1;
        exp_lost = exp_lost + 1;
        chk("bp_held_peak", int'(result_peak), 300);
        chk("bp_lost", int'(lost_count), exp_lost);
        chk("bp_pcount", int'(pulse_count), exp_pc);
        idle(6);
        step(16'sd250);
        result_ready = 1'b1;
        step(16'sd0);
        exp_pc = exp_pc + 1;
        chk("bp_swap_valid", int'(result_valid), 1);
        chk("bp_swap_peak", int'(result_peak), 250);
        chk("bp_swap_lost", int'(lost_count), exp_lost);
        step(IDLE_V);
        chk("bp_final_valid", int'(result_valid), 0);
        idle(6);

        // Enable abort mid-pulse.
        step(16'sd200); step(16'sd300);
        chk("ab_busy_track", int'(busy), 1);
        enable = 1'b0;
        step(16'sd300);
        chk("ab_busy_off", int'(busy), 0);
        enable = 1'b1;
        idle(2);
        chk("ab_no_record", int'(result_valid), 0);
        chk("ab_pcount", int'(pulse_count), exp_pc);

        // Dead time: samples in the 4 dead cycles are ignored, the first idle cycle is live.
        step(16'sd200); step(16'sd0);
        exp_pc = exp_pc + 1;
        step(IDLE_V); step(16'sd200); step(16'sd200);
        chk("dt_busy_dead", int'(busy), 1);
        step(16'sd200);
        chk("dt_busy_idle", int'(busy), 0);
        step(IDLE_V);
        chk("dt_ignored_pcount", int'(pulse_count), exp_pc);
        chk("dt_ignored_valid", int'(result_valid), 0);
        step(16'sd200); step(IDLE_V);
        exp_pc = exp_pc + 1;
        chk("dt_live_pcount", int'(pulse_count), exp_pc);
        chk("dt_live_width", int'(result_width), 1);
        idle(6);

        // Width saturation across a timestamp wrap; peak lands at ts 64 after wrapping.
        while (tb_ts != 16'd65400) step(IDLE_V);
        for (int k = 0; k < 200; k++) step(16'sd500);
        step(16'sd600);
        for (int k = 0; k < 99; k++) step(16'sd500);
        step(IDLE_V);
        exp_pc = exp_pc + 1;
        chk("sat_width", int'(result_width), 255);
        chk("sat_peak", int'(result_peak), 600);
        chk("wrap_time", int'(result_time), 64);
        chk("sat_pile", int'(result_pileup), 0);
        chk("sat_pcount", int'(pulse_count), exp_pc);
        idle(6);

        // Asynchronous reset mid-pulse with a record held.
        result_ready = 1'b0;
        step(16'sd200); step(IDLE_V);
        chk("ar_held_valid", int'(result_valid), 1);
        idle(6);
        step(16'sd300);
        reset = 1'b0;
        #1;
        chk("ar_valid", int'(result_valid), 0);
        chk("ar_peak", int'(result_peak), 0);
        chk("ar_time", int'(result_time), 0);
        chk("ar_width", int'(result_width), 0);
        chk("ar_pcount", int'(pulse_count), 0);
        chk("ar_lost", int'(lost_count), 0);
        chk("ar_busy", int'(busy), 0);
        @(negedge clk);
        reset        = 1'b1;
        result_ready = 1'b1;
        tb_ts        = 16'd0;
        step(16'sd300); step(IDLE_V);
        chk("ar_fresh_valid", int'(result_valid), 1);
        chk("ar_fresh_time", int'(result_time), 0);
        chk("ar_fresh_width", int'(result_width), 1);
        chk("ar_fresh_pcount", int'(pulse_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_peak_analyzer.md
Name: pulse_peak_analyzer

Overview:
- Consumer end of the signal chain: takes one sample per clock from a filter output (or directly from the exponential signal generator) and turns the stream into per-pulse records.
- Detects threshold crossings and tracks peak amplitude, peak timestamp and width for each pulse.
- Flags pile-up (overlaid pulses) and presents each record on a valid/ready port for readout.
- Sits beside the filter instances in the filter top level; it lets the generator's overlay/rate/delay settings be checked against measured pulses.

Parameters:
- DATA_WIDTH, 16, width of the signed two's-complement input sample and the threshold.
- TIME_WIDTH, 16, width of the free-running timestamp counter and of result_time.
- WIDTH_BITS, 8, width of the pulse-width field (saturating).
- CNT_WIDTH, 16, width of the pulse and lost counters (saturating).
- DEAD_TIME, 4, cycles the input is ignored after a pulse ends; 0 means no dead time.
- PILEUP_HYST, 32, unsigned rise above the post-peak minimum that declares pile-up.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; low clears all state immediately.
- enable  input  1  high = analysis active; low = return to IDLE and discard any in-progress pulse.
- threshold  input  DATA_WIDTH  signed detection level; sampled every clock.
- input_data  input  DATA_WIDTH  signed sample stream, one valid sample per clock.
- result_valid  output  1  record available.
- result_ready  input  1  consumer accepts the record when result_valid and result_ready are both high at a rising edge.
- result_peak  output  DATA_WIDTH  signed peak amplitude.
- result_time  output  TIME_WIDTH  timestamp of the peak sample.
- result_width  output  WIDTH_BITS  number of samples above threshold.
- result_pileup  output  1  pile-up detected in this pulse.
- pulse_count  output  CNT_WIDTH  pulses completed; saturating.
- lost_count  output  CNT_WIDTH  records dropped because of backpressure; saturating.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (reset low): FSM goes to IDLE. The timestamp counter ts and every output go to 0, including result_valid, all result fields, both counters and busy.
- ts increments every clock and wraps from 2^TIME_WIDTH-1 to 0. The "time" of a sample is the value of ts at the edge that samples it.
- All comparisons are signed.
- Above-threshold means input_data > threshold, strictly.
- FSM states:
  - IDLE: when enable=1 and the sample is above threshold, go to TRACK. Load peak=input_data, peak_time=ts, width=1, valley=input_data, pileup=0.
  - TRACK, sample still above threshold:
    - width increments, saturating at 2^WIDTH_BITS-1.
    - If input_data > peak (strict), update peak and peak_time, and set valley=input_data. Ties keep the earlier peak.
    - Otherwise, if input_data < valley, set valley=input_data.
    - If input_data > valley+PILEUP_HYST (computed at DATA_WIDTH+1 bits, no overflow), set pileup=1. The flag stays set for the rest of the pulse.
  - TRACK, sample at or below threshold: the pulse ends. Commit the record, increment pulse_count, and go to DEAD (or to IDLE if DEAD_TIME=0).
  - DEAD: count DEAD_TIME cycles while ignoring input, then go to IDLE. A sample above threshold on the first IDLE cycle starts a new pulse.
- Commit timing: the result registers update on the same edge that samples the terminating sample, so result_valid is high in the next cycle (latency 1 from the end sample).
- Output register rules:
  - If result_valid=0, or the current record is being accepted on this edge (valid and ready both high), load the new record and result_valid=1.
  - Otherwise keep the old record unchanged and increment lost_count. pulse_count still increments.
  - When a record is accepted and none is committed on that edge, result_valid=0.
- enable=0 at any edge: FSM goes to IDLE and the pulse in progress is discarded with no record and no count. A record already in the output register is unaffected.
- Threshold changes mid-pulse take effect on the next sample.
- busy=1 in TRACK and in DEAD.

Test Plan:
- Reset: assert reset low mid-pulse with result_valid=1 -> all outputs read 0 asynchronously; after release, the first above-threshold sample starts a fresh pulse.
- Single pulse: threshold=100, DEAD_TIME=4, input 50,150,300,200,90 at ts 10..14, ready=1 -> result_valid high after the ts=14 edge with peak=300, time=12, width=3, pileup=0; pulse_count=1.
- Pile-up and ties: input 150,300,200,260,300,80 with PILEUP_HYST=32 -> pileup=1 (260>232); peak=300 and time is the first 300 (tie keeps the earlier sample); width=5.
- Backpressure: ready=0, two separated pulses -> the first record is held unchanged, lost_count=1, pulse_count=2. Then a pulse ends on the same edge that ready=1 accepts the held record -> the new record loads, result_valid stays 1, lost_count unchanged.
- Dead time and width saturation: a second pulse starting 2 cycles after the first ends (DEAD_TIME=4) -> ignored, no record. An input held at 500 for 300 cycles -> width=255 (saturated). ts wrap from 65535 to 0 inside a pulse -> peak time reported correctly.
- Enable abort and negative data: enable low mid-pulse -> no record, pulse_count unchanged, busy=0 next cycle. threshold=-50 with input -40,-10,-60 -> peak=-10, width=2.
